vga_frame_ctrl: RTL and testbench
=================================

VGA_FRAME_CTRL -- requirements
Module: vga_frame_ctrl

Interface
REQ-001 SHALL have parameter Y_ACTIVE, default 600: number of visible lines after reset.
REQ-002 SHALL have parameter Y_FRONT, default 637: line count of active plus front porch, i.e. the first line of vsync.
REQ-003 SHALL have parameter Y_BACK, default 643: total minus back porch, i.e. the first line after vsync.
REQ-004 SHALL have parameter Y_TOTAL, default 666: the last ypos value before wrap.
REQ-005 SHALL have port clk, input, 1 bit: the single pixel clock, shared with the horizontal generator.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: run request.
REQ-008 SHALL have port newline_in, input, 1 bit: one-cycle end-of-line pulse from the horizontal generator.
REQ-009 SHALL have port hactive_in, input, 1 bit: horizontal display-active flag.
REQ-010 SHALL have ports cfg_valid (input, 1 bit) and cfg_ready (output, 1 bit): the configuration handshake.
REQ-011 SHALL have ports cfg_active, cfg_front, cfg_back, cfg_total, each input, 11 bits: the new vertical timing.
REQ-012 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a configuration is rejected.
REQ-013 SHALL have port ypos, output, 11 bits: current line number.
REQ-014 SHALL have ports vsync, vactive, video_on and frame_start, each output, 1 bit.
REQ-015 SHALL have port busy, output, 1 bit: high while in RUN.

Function
REQ-016 SHALL implement the states IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE on the first edge with enable=0, abandoning the frame mid-operation.
REQ-017 SHALL, in RUN on an edge with newline_in=1, set ypos to ypos+1 if ypos<total, otherwise to 0; with newline_in=0, ypos SHALL hold.
REQ-018 SHALL register vsync, vactive and frame_start from the next ypos value, so that they change on the same edge as ypos.
REQ-019 SHALL drive vactive=1 iff ypos<active.
REQ-020 SHALL drive vsync=0 iff front<=ypos<back, and 1 otherwise (active-low sync).
REQ-021 SHALL pulse frame_start for 1 cycle on every wrap to 0 and on IDLE->RUN entry.
REQ-022 SHALL drive video_on as hactive_in AND vactive, registered, giving 1-cycle latency.
REQ-023 SHALL, in IDLE, hold ypos=0, vsync=1, vactive=0 and video_on=0.
REQ-024 SHALL hold one shadow config slot: cfg_ready=1 when the slot is empty; a transfer occurs on cfg_valid AND cfg_ready.
REQ-025 SHALL apply a shadowed config to the live timing registers on the wrap edge in RUN, or on the next edge in IDLE, and then free the slot.
REQ-026 SHALL, when a config is accepted on the same edge as a wrap, apply it at the following wrap, not the current one.
REQ-027 SHALL keep the live timing unchanged when cfg_valid is held with the slot full; it SHALL stall without loss of data.
REQ-028 SHALL use unsigned 11-bit comparisons everywhere; ypos SHALL never exceed total.

Reset
REQ-029 SHALL, on rst_n=0 asynchronously, enter IDLE, set ypos=0, vsync=1, vactive=0, video_on=0, frame_start=0, cfg_err=0 and busy=0, and empty the shadow slot.
REQ-030 SHALL load the live timing from the parameters on reset; a reset mid-operation SHALL discard any pending config.

Configuration
REQ-031 SHALL, with VFRAME_CFG_CHECK_EN defined, accept a config only if active<front<back<=total; otherwise it SHALL complete the handshake, discard the data, pulse cfg_err for 1 cycle and leave the slot empty.
REQ-032 SHALL, without VFRAME_CFG_CHECK_EN, accept every config unchecked and tie cfg_err to 0.

Verification
REQ-033 SHALL cover: reset, then enable=1 with newline_in every 1040 cycles -> frame_start at entry, vactive falls at ypos=600, vsync is 0 for ypos 637..642, and wrap occurs after ypos=666.
REQ-034 SHALL cover: a config (480,490,492,524) accepted at ypos=100 -> the old timing holds to the wrap, the new timing applies from ypos=0, and cfg_ready returns to 1.
REQ-035 SHALL cover: a config accepted on the wrap edge -> applied one frame later; a second cfg_valid meanwhile sees cfg_ready=0.
REQ-036 SHALL cover, with VFRAME_CFG_CHECK_EN: config (500,490,492,524) -> cfg_err=1 for 1 cycle and timing unchanged; without the macro -> accepted.
REQ-037 SHALL cover: enable=0 at ypos=300 -> IDLE next edge with ypos=0 and vsync=1; re-enable -> frame_start and ypos=0.
REQ-038 SHALL cover: rst_n asserted mid-frame with a pending config -> outputs reach reset values immediately, and after release the parameter timing is active.

Source files
------------

// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - vertical frame timing controller with one shadowed timing config slot
// Optional build macro VFRAME_CFG_CHECK_EN: reject configs unless active<front<back<=total.
module vga_frame_ctrl #(
  parameter int Y_ACTIVE = 600,
  parameter int Y_FRONT  = 637,
  parameter int Y_BACK   = 643,
  parameter int Y_TOTAL  = 666
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        newline_in,
  input  logic        hactive_in,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [10:0] cfg_active,
  input  logic [10:0] cfg_front,
  input  logic [10:0] cfg_back,
  input  logic [10:0] cfg_total,
  output logic        cfg_err,
  output logic [10:0] ypos,
  output logic        vsync,
  output logic        vactive,
  output logic        video_on,
  output logic        frame_start,
  output logic        busy
);

  localparam logic [10:0] P_ACTIVE = 11'(Y_ACTIVE);
  localparam logic [10:0] P_FRONT  = 11'(Y_FRONT);
  localparam logic [10:0] P_BACK   = 11'(Y_BACK);
  localparam logic [10:0] P_TOTAL  = 11'(Y_TOTAL);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [10:0] r_active, r_front, r_back, r_total;
  logic [10:0] r_sh_active, r_sh_front, r_sh_back, r_sh_total;
  logic        r_slot_full;

  logic [10:0] r_ypos;
  logic        r_vsync, r_vactive, r_video_on, r_frame_start;

  logic        w_xfer, w_cfg_ok, w_apply, w_run_nxt;
  logic        w_entry, w_wrap;
  logic [10:0] w_ypos_nxt;
  logic [10:0] w_active_nxt, w_front_nxt, w_back_nxt, w_total_nxt;
  logic        w_vsync_nxt, w_vactive_nxt, w_video_on_nxt, w_frame_start_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable)  w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line counter and frame events; leaving RUN abandons the frame immediately.
  always_comb begin
    w_entry    = 1'b0;
    w_wrap     = 1'b0;
    w_ypos_nxt = r_ypos;
    case (r_state)
      S_IDLE: begin
        w_ypos_nxt = '0;
        w_entry    = enable;
      end
      S_RUN: begin
        if (!enable) begin
          w_ypos_nxt = '0;
        end else if (newline_in) begin
          if (r_ypos < r_total) begin
            w_ypos_nxt = r_ypos + 11'd1;
          end else begin
            w_ypos_nxt = '0;
            w_wrap     = 1'b1;
          end
        end
      end
      default: w_ypos_nxt = '0;
    endcase
  end

`ifdef VFRAME_CFG_CHECK_EN
  assign w_cfg_ok = (cfg_active < cfg_front) && (cfg_front < cfg_back) && (cfg_back <= cfg_total);
`else
  assign w_cfg_ok = 1'b1;
`endif

  assign cfg_ready = !r_slot_full;
  assign w_xfer    = cfg_valid && !r_slot_full;
  // A config accepted on a wrap edge only fills the slot, so it waits for the next wrap.
  assign w_apply   = r_slot_full && ((r_state == S_IDLE) || w_wrap);

  assign w_active_nxt = w_apply ? r_sh_active : r_active;
  assign w_front_nxt  = w_apply ? r_sh_front  : r_front;
  assign w_back_nxt   = w_apply ? r_sh_back   : r_back;
  assign w_total_nxt  = w_apply ? r_sh_total  : r_total;

  // Vertical flags are derived from next ypos and next timing so they move with ypos.
  assign w_run_nxt         = (w_state_nxt == S_RUN);
  assign w_vactive_nxt     = w_run_nxt && (w_ypos_nxt < w_active_nxt);
  assign w_vsync_nxt       = !(w_run_nxt && (w_ypos_nxt >= w_front_nxt) && (w_ypos_nxt < w_back_nxt));
  assign w_frame_start_nxt = w_entry || w_wrap;
  assign w_video_on_nxt    = w_run_nxt && hactive_in && r_vactive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ypos        <= '0;
      r_vsync       <= 1'b1;
      r_vactive     <= 1'b0;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_ypos        <= w_ypos_nxt;
      r_vsync       <= w_vsync_nxt;
      r_vactive     <= w_vactive_nxt;
      r_video_on    <= w_video_on_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= P_ACTIVE;
      r_front     <= P_FRONT;
      r_back      <= P_BACK;
      r_total     <= P_TOTAL;
      r_sh_active <= '0;
      r_sh_front  <= '0;
      r_sh_back   <= '0;
      r_sh_total  <= '0;
      r_slot_full <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      r_front  <= w_front_nxt;
      r_back   <= w_back_nxt;
      r_total  <= w_total_nxt;
      if (w_apply) begin
        r_slot_full <= 1'b0;
      end else if (w_xfer && w_cfg_ok) begin
        r_sh_active <= cfg_active;
        r_sh_front  <= cfg_front;
        r_sh_back   <= cfg_back;
        r_sh_total  <= cfg_total;
        r_slot_full <= 1'b1;
      end
    end
  end

`ifdef VFRAME_CFG_CHECK_EN
  logic r_cfg_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cfg_err <= 1'b0;
    else        r_cfg_err <= w_xfer && !w_cfg_ok;
  end
  assign cfg_err = r_cfg_err;
`else
  assign cfg_err = 1'b0;
`endif

  assign ypos        = r_ypos;
  assign vsync       = r_vsync;
  assign vactive     = r_vactive;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;
  assign busy        = (r_state == S_RUN);

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb/tb_vga_frame_ctrl.sv - scoreboard bench for vga_frame_ctrl against a line-level reference model
module tb_vga_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, newline_in = 1'b0, hactive_in = 1'b0, cfg_valid = 1'b0;
  logic [10:0] cfg_active = '0, cfg_front = '0, cfg_back = '0, cfg_total = '0;
  logic        cfg_ready, cfg_err, vsync, vactive, video_on, frame_start, busy;
  logic [10:0] ypos;

  vga_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .newline_in(newline_in), .hactive_in(hactive_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_active(cfg_active), .cfg_front(cfg_front),
    .cfg_back(cfg_back), .cfg_total(cfg_total), .cfg_err(cfg_err), .ypos(ypos), .vsync(vsync),
    .vactive(vactive), .video_on(video_on), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] y;
    logic vs, va, vo, fs, bz, rdy, err;
  } exp_t;
  exp_t q[$];

  int n_checks = 0, n_fail = 0;

  // Reference model: the visible frame as a line number plus timing table.
  bit m_run, m_full, m_vs, m_va, m_vo, m_fs, m_err, m_acc;
  int m_y, m_wraps;
  int m_a, m_f, m_b, m_t;
  int s_a, s_f, s_b, s_t;
  bit tog;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  function automatic bit cfg_legal(input int a, input int f, input int b, input int t);
`ifdef VFRAME_CFG_CHECK_EN
    return (a < f) && (f < b) && (b <= t);
`else
    return 1'b1;
`endif
  endfunction

  task automatic m_reset();
    m_run = 0; m_full = 0; m_y = 0;
    m_vs = 1; m_va = 0; m_vo = 0; m_fs = 0; m_err = 0; m_acc = 0;
    m_a = 600; m_f = 637; m_b = 643; m_t = 666;
  endtask

  task automatic model_edge();
    exp_t e;
    bit was_run, wrap, entry, ok;
    if (!rst_n) begin
      m_reset();
    end else begin
      was_run = m_run; wrap = 0; entry = 0;
      m_vo  = was_run && enable && hactive_in && m_va;
      m_acc = cfg_valid && !m_full;
      ok    = cfg_legal(cfg_active, cfg_front, cfg_back, cfg_total);
      if (was_run) begin
        if (!enable) begin m_run = 0; m_y = 0; end
        else if (newline_in) begin
          if (m_y < m_t) m_y = m_y + 1;
          else begin m_y = 0; wrap = 1; m_wraps++; end
        end
      end else if (enable) begin
        m_run = 1; m_y = 0; entry = 1;
      end
      if (m_full && (!was_run || wrap)) begin
        m_a = s_a; m_f = s_f; m_b = s_b; m_t = s_t; m_full = 0;
      end else if (m_acc && ok) begin
        s_a = cfg_active; s_f = cfg_front; s_b = cfg_back; s_t = cfg_total; m_full = 1;
      end
      m_err = m_acc && !ok;
      m_va  = m_run && (m_y < m_a);
      m_vs  = !(m_run && m_y >= m_f && m_y < m_b);
      m_fs  = wrap || entry;
    end
    e.y = 11'(m_y); e.vs = m_vs; e.va = m_va; e.vo = m_vo; e.fs = m_fs;
    e.bz = m_run; e.rdy = !m_full; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic step(input bit en, input bit nl, input bit cv);
    enable = en; newline_in = nl; cfg_valid = cv; hactive_in = 1'($urandom_range(1));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int a, input int f, input int b, input int t);
    cfg_active = 11'(a); cfg_front = 11'(f); cfg_back = 11'(b); cfg_total = 11'(t);
  endtask

  task automatic run_until_y(input int target, input int maxc);
    int n = 0;
    while (!(m_run && m_y == target) && n < maxc) begin
      tog = !tog; step(1, tog, 0); n++;
    end
    if (!(m_run && m_y == target)) timeout("run_until_y");
  endtask

  task automatic run_frames(input int nfr);
    int start = m_wraps, n = 0;
    while (m_wraps < start + nfr && n < 20000) begin
      tog = !tog; step(1, tog, 0); n++;
    end
    if (m_wraps < start + nfr) timeout("run_frames");
  endtask

  task automatic push_cfg_until_taken(input int a, input int f, input int b, input int t);
    int n = 0;
    set_cfg(a, f, b, t);
    m_acc = 0;
    while (!m_acc && n < 5000) begin
      tog = !tog; step(1, tog, 1); n++;
    end
    if (!m_acc) timeout("cfg_accept");
    cfg_valid = 0;
  endtask

  task automatic rand_cfg();
    int t, a, f, b;
    t = $urandom_range(200, 20);
    if ($urandom_range(3) == 0) begin
      set_cfg($urandom_range(200), $urandom_range(200), $urandom_range(200), t);
    end else begin
      a = $urandom_range(t - 6, 1);
      f = $urandom_range(t - 3, a + 1);
      b = $urandom_range(t, f + 1);
      set_cfg(a, f, b, t);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) timeout("scoreboard_empty");
      else begin
        e = q.pop_front();
        chk("ypos", ypos, e.y);
        chk("vsync", vsync, e.vs);
        chk("vactive", vactive, e.va);
        chk("video_on", video_on, e.vo);
        chk("frame_start", frame_start, e.fs);
        chk("busy", busy, e.bz);
        chk("cfg_ready", cfg_ready, e.rdy);
        chk("cfg_err", cfg_err, e.err);
      end
    end
  end

  initial begin : driver
    m_reset();
    m_wraps = 0; tog = 0;
    repeat (3) step(0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);
    // Default timing: entry pulse, vactive edge at 600, vsync low 637..642, wrap after 666.
    step(1, 0, 0);
    run_frames(1);
    run_until_y(100, 2000);
    push_cfg_until_taken(480, 490, 492, 524);
    run_frames(2);
    // Config accepted on the wrap edge waits a frame; a second request stalls meanwhile.
    run_until_y(m_t, 3000);
    set_cfg(480, 490, 492, 524);
    m_acc = 0;
    step(1, 1, 1);
    if (!m_acc) timeout("wrap_accept");
    push_cfg_until_taken(300, 310, 315, 350);
    run_frames(2);
    // Out-of-order timing: rejected with the check, applied without it.
    set_cfg(500, 490, 492, 524);
    step(1, 0, 1);
    cfg_valid = 0;
    run_frames(2);
    push_cfg_until_taken(600, 637, 643, 666);
    run_frames(1);
    // Drop enable mid-frame, idle, re-enter.
    run_until_y(300, 2000);
    step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    step(1, 0, 0);
    repeat (10) begin tog = !tog; step(1, tog, 0); end
    // Randomised traffic including short frames and illegal configs.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) rand_cfg();
      step($urandom_range(31) != 0, 1'($urandom_range(1)), $urandom_range(5) == 0);
    end
    cfg_valid = 0;
    push_cfg_until_taken(600, 637, 643, 666);
    run_frames(1);
    // Asynchronous reset mid-frame with a pending config.
    run_until_y(40, 2000);
    push_cfg_until_taken(480, 490, 492, 524);
    repeat (5) begin tog = !tog; step(1, tog, 0); end
    rst_n = 1'b0;
    #1;
    chk("async_ypos", ypos, 0);
    chk("async_vsync", vsync, 1);
    chk("async_vactive", vactive, 0);
    chk("async_video_on", video_on, 0);
    chk("async_frame_start", frame_start, 0);
    chk("async_busy", busy, 0);
    chk("async_cfg_ready", cfg_ready, 1);
    chk("async_cfg_err", cfg_err, 0);
    m_reset();
    repeat (2) step(1, 1, 0);
    rst_n = 1'b1;
    step(1, 0, 0);
    run_frames(1);
    run_until_y(645, 2000);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
